regbank_mp: RTL and testbench

Parametrised register bank: NUM_REGS general registers with R0 hard-wired to zero, plus a dedicated stack-pointer register at index NUM_REGS. It provides two combinational read ports with optional write-through bypass, one write port, and hardware push/pop adjustment of SP. A handshaked dump port walks the whole bank one entry per cycle for testbench and debug readout. It sits between instruction decode and the ALU/writeback stage of the single-cycle datapath.

---
 rtl/regbank_mp.sv | 136 +++++++++++++
 tb/tb_regbank_mp.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/regbank_mp.sv
// Register bank: R0 hard-wired to zero, stack pointer at index NUM_REGS, two bypassed
// read ports, one write port, push/pop SP adjustment and a handshaked dump walker.
module regbank_mp #(
  parameter int WIDTH    = 32,
  parameter int NUM_REGS = 16,
  parameter int ADDR_W   = 5,
  parameter int SP_RESET = 1023,
  parameter int SP_STEP  = 1,
  parameter int BYPASS   = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] rs_addr,
  input  logic [ADDR_W-1:0] rt_addr,
  output logic [WIDTH-1:0]  rs_data,
  output logic [WIDTH-1:0]  rt_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [WIDTH-1:0]  wr_data,
  input  logic [1:0]        sp_op,
  output logic [WIDTH-1:0]  sp_out,
  input  logic              dump_start,
  output logic              dump_valid,
  input  logic              dump_ready,
  output logic [ADDR_W-1:0] dump_addr,
  output logic [WIDTH-1:0]  dump_data,
  output logic              dump_busy,
  output logic              dump_done
);

  localparam int                IDX_W   = $clog2(NUM_REGS);
  localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(NUM_REGS);

  typedef enum logic {S_IDLE, S_SCAN} state_t;

  logic [WIDTH-1:0]  r_regs [NUM_REGS];
  logic [WIDTH-1:0]  r_sp;
  state_t            r_state;
  logic [ADDR_W-1:0] r_idx;
  logic [WIDTH-1:0]  r_dump_data;
  logic              r_dump_valid;
  logic              r_dump_busy;
  logic              r_dump_done;

  logic w_reg_write;
  logic w_sp_write;

  // Registered (pre-edge) value of any bank index; out-of-range and R0 read as zero.
  function automatic logic [WIDTH-1:0] f_entry(input logic [ADDR_W-1:0] a);
    if (a == '0 || a > SP_ADDR) return '0;
    else if (a == SP_ADDR)      return r_sp;
    else                        return r_regs[a[IDX_W-1:0]];
  endfunction

  function automatic logic [WIDTH-1:0] f_read(input logic [ADDR_W-1:0] a);
    if (BYPASS != 0 && wr_en && wr_addr == a && a != '0 && a <= SP_ADDR) return wr_data;
    else                                                                  return f_entry(a);
  endfunction

  assign w_reg_write = wr_en && wr_addr != '0 && wr_addr < SP_ADDR;
  assign w_sp_write  = wr_en && wr_addr == SP_ADDR;

  // NOTE: always_comb (not assign) so the block also re-evaluates when the state the
  // functions read changes, not only when the address arguments change.
  always_comb begin
    rs_data = f_read(rs_addr);
    rt_data = f_read(rt_addr);
  end

  // NOTE: the register array is reset explicitly because the bank must read as zero
  // after reset; this rules out mapping it onto a RAM macro.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
      r_sp <= WIDTH'(SP_RESET);
    end else begin
      if (w_reg_write) r_regs[wr_addr[IDX_W-1:0]] <= wr_data;
      // An explicit SP write takes priority over a same-cycle push/pop.
      if (w_sp_write) begin
        r_sp <= wr_data;
      end else begin
        case (sp_op)
          2'b01:   r_sp <= r_sp - WIDTH'(SP_STEP);
          2'b10:   r_sp <= r_sp + WIDTH'(SP_STEP);
          default: r_sp <= r_sp;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_idx        <= '0;
      r_dump_data  <= '0;
      r_dump_valid <= 1'b0;
      r_dump_busy  <= 1'b0;
      r_dump_done  <= 1'b0;
    end else begin
      r_dump_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (dump_start) begin
            r_idx        <= '0;
            r_dump_data  <= f_entry('0);
            r_dump_valid <= 1'b1;
            r_dump_busy  <= 1'b1;
            r_state      <= S_SCAN;
          end
        end
        S_SCAN: begin
          if (r_dump_valid && dump_ready) begin
            if (r_idx < SP_ADDR) begin
              r_idx       <= r_idx + ADDR_W'(1);
              r_dump_data <= f_entry(r_idx + ADDR_W'(1));
            end else begin
              r_dump_valid <= 1'b0;
              r_dump_busy  <= 1'b0;
              r_dump_done  <= 1'b1;
              r_state      <= S_IDLE;
            end
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign sp_out     = r_sp;
  assign dump_valid = r_dump_valid;
  assign dump_addr  = r_idx;
  assign dump_data  = r_dump_data;
  assign dump_busy  = r_dump_busy;
  assign dump_done  = r_dump_done;

endmodule

// File: tb/tb_regbank_mp.sv
// Self-checking bench for regbank_mp: directed vectors with literal expectations plus
// a per-cycle comparison against an array-based model of the bank and dump walk.
module tb_regbank_mp;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [4:0]  rs_addr = '0, rt_addr = '0, wr_addr = '0;
  logic [31:0] rs_data, rt_data, wr_data = '0, sp_out, dump_data;
  logic        wr_en = 1'b0, dump_start = 1'b0, dump_ready = 1'b0;
  logic [1:0]  sp_op = 2'b00;
  logic        dump_valid, dump_busy, dump_done;
  logic [4:0]  dump_addr;

  int n_cmp = 0;
  int n_err = 0;

  regbank_mp dut (
    .clk(clk), .reset(reset),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rs_data(rs_data), .rt_data(rt_data),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .sp_op(sp_op), .sp_out(sp_out),
    .dump_start(dump_start), .dump_valid(dump_valid), .dump_ready(dump_ready),
    .dump_addr(dump_addr), .dump_data(dump_data),
    .dump_busy(dump_busy), .dump_done(dump_done)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model: 16 general registers, SP, and the dump cursor as plain variables.
  logic [31:0] m_regs [16];
  logic [31:0] m_sp    = 32'd1023;
  bit          m_busy  = 1'b0;
  bit          m_done  = 1'b0;
  int          m_idx   = 0;
  logic [31:0] m_ddata = '0;

  function automatic logic [31:0] m_entry(input int a);
    if (a == 0 || a > 16) return 32'd0;
    if (a == 16)          return m_sp;
    return m_regs[a];
  endfunction

  function automatic logic [31:0] m_read(input int a);
    if (wr_en && int'(wr_addr) == a && a >= 1 && a <= 16) return wr_data;
    return m_entry(a);
  endfunction

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) m_regs[i] = '0;
      m_sp = 32'd1023; m_busy = 0; m_done = 0; m_idx = 0; m_ddata = '0;
    end else begin
      m_done = 0;
      if (!m_busy) begin
        if (dump_start) begin
          m_busy = 1; m_idx = 0; m_ddata = m_entry(0);
        end
      end else if (dump_ready) begin
        if (m_idx < 16) begin
          m_idx++; m_ddata = m_entry(m_idx);
        end else begin
          m_busy = 0; m_done = 1;
        end
      end
      if (wr_en && wr_addr == 5'd16) begin
        m_sp = wr_data;
      end else begin
        if (wr_en && wr_addr >= 5'd1 && wr_addr <= 5'd15) m_regs[int'(wr_addr)] = wr_data;
        if (sp_op == 2'b01)      m_sp = m_sp - 32'd1;
        else if (sp_op == 2'b10) m_sp = m_sp + 32'd1;
      end
    end
  end

  always @(negedge clk) begin
    check("rs_data", rs_data, m_read(int'(rs_addr)));
    check("rt_data", rt_data, m_read(int'(rt_addr)));
    check("sp_out", sp_out, m_sp);
    check("dump_valid", dump_valid, m_busy);
    check("dump_busy", dump_busy, m_busy);
    check("dump_done", dump_done, m_done);
    if (m_busy) begin
      check("dump_addr", dump_addr, m_idx);
      check("dump_data", dump_data, m_ddata);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_addr(input int tgt);
    int n = 0;
    while (int'(dump_addr) != tgt && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("wait_addr_timeout", 64'd0, 64'd1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (dump_busy && n < 40) begin
      tick();
      n++;
    end
    if (n >= 40) check("wait_idle_timeout", 64'd0, 64'd1);
  endtask

  initial begin
    int beats, cyc;
    tick(); tick();
    reset = 1'b0;

    // Reset state of every address on both ports
    for (int a = 0; a < 32; a++) begin
      rs_addr = 5'(a);
      rt_addr = 5'(31 - a);
      #1;
      check("reset_rs", rs_data, (a == 16) ? 32'd1023 : 32'd0);
      check("reset_rt", rt_data, ((31 - a) == 16) ? 32'd1023 : 32'd0);
    end
    check("reset_sp", sp_out, 32'd1023);
    tick();

    // Bypass, R0 write, out-of-range write
    wr_en = 1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rs_addr = 5'd5; #1;
    check("bypass_r5", rs_data, 32'hDEADBEEF);
    tick(); wr_en = 0; #1;
    check("stored_r5", rs_data, 32'hDEADBEEF);
    wr_en = 1; wr_addr = 5'd0; wr_data = 32'd7; rs_addr = 5'd0; #1;
    check("r0_no_bypass", rs_data, 32'd0);
    tick(); wr_en = 0; #1;
    check("r0_still_zero", rs_data, 32'd0);
    wr_en = 1; wr_addr = 5'd20; wr_data = 32'd55; rs_addr = 5'd20; #1;
    check("addr20_no_bypass", rs_data, 32'd0);
    tick(); wr_en = 0; #1;
    check("addr20_zero", rs_data, 32'd0);

    // Push/pop, wrap, write-over-push priority
    sp_op = 2'b01; tick(); check("push1", sp_out, 32'd1022);
    tick(); check("push2", sp_out, 32'd1021);
    tick(); check("push3", sp_out, 32'd1020);
    sp_op = 2'b10; tick(); check("pop1", sp_out, 32'd1021);
    sp_op = 2'b00; wr_en = 1; wr_addr = 5'd16; wr_data = 32'd0;
    tick(); wr_en = 0; check("sp_zero", sp_out, 32'd0);
    sp_op = 2'b01; tick(); check("push_wrap", sp_out, 32'hFFFFFFFF);
    wr_en = 1; wr_addr = 5'd16; wr_data = 32'd500;
    tick(); wr_en = 0; sp_op = 2'b00; check("write_beats_push", sp_out, 32'd500);

    // Load R1..R15 with i*3 and run a full-speed dump
    for (int i = 1; i < 16; i++) begin
      wr_en = 1; wr_addr = 5'(i); wr_data = 32'(i * 3);
      tick();
    end
    wr_en = 0;
    dump_start = 1; dump_ready = 1;
    tick(); dump_start = 0;
    beats = 0; cyc = 0;
    while (beats < 17 && cyc < 40) begin
      if (dump_valid) begin
        check("dump_beat_addr", dump_addr, beats);
        check("dump_beat_data", dump_data, (beats == 16) ? 32'd500 : 32'(beats * 3));
        beats++;
      end
      tick();
      cyc++;
    end
    check("dump_beats", beats, 17);
    check("dump_cycles", cyc, 17);
    check("done_pulse", dump_done, 1'b1);
    check("busy_fell", dump_busy, 1'b0);
    check("valid_fell", dump_valid, 1'b0);
    tick();
    check("done_one_cycle", dump_done, 1'b0);

    // Back-pressure at addr 6 while R6 is rewritten
    dump_start = 1; tick(); dump_start = 0;
    wait_addr(6);
    dump_ready = 0; wr_en = 1; wr_addr = 5'd6; wr_data = 32'd99;
    for (int k = 0; k < 4; k++) begin
      tick(); wr_en = 0;
      check("stall_addr", dump_addr, 5'd6);
      check("stall_data", dump_data, 32'd18);
    end
    dump_ready = 1; tick();
    check("resume_addr", dump_addr, 5'd7);
    check("resume_data", dump_data, 32'd21);
    wait_idle();
    dump_start = 1; tick(); dump_start = 0;
    wait_addr(6);
    check("second_dump_r6", dump_data, 32'd99);
    wait_idle();

    // Reset in the middle of a dump
    dump_start = 1; tick(); dump_start = 0;
    wait_addr(9);
    reset = 1; #1;
    check("rst_valid_drop", dump_valid, 1'b0);
    check("rst_busy_drop", dump_busy, 1'b0);
    check("rst_sp", sp_out, 32'd1023);
    rs_addr = 5'd6; #1;
    check("rst_r6_cleared", rs_data, 32'd0);
    tick(); reset = 0;
    dump_start = 1; tick(); dump_start = 0;
    check("restart_valid", dump_valid, 1'b1);
    check("restart_addr", dump_addr, 5'd0);
    check("restart_data", dump_data, 32'd0);
    wait_idle();
    tick(); tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
